// File: rtl/proc_dpath_alu_opnd_stage.sv
// proc_dpath_alu_opnd_stage: D->X operand stage feeding the ALU, with RAW forwarding or interlock.
// Define PROC_OPND_BYPASS_EN to forward from X/M/W; otherwise dependents wait until the producer leaves W.
module proc_dpath_alu_opnd_stage #(
   parameter int p_nbits = 32,
   parameter int p_naddr = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               d_val,
   output logic               d_rdy,
   input  logic [p_naddr-1:0] d_rs1_addr,
   input  logic [p_naddr-1:0] d_rs2_addr,
   input  logic [p_nbits-1:0] d_rs1_data,
   input  logic [p_nbits-1:0] d_rs2_data,
   input  logic [p_nbits-1:0] d_imm,
   input  logic               d_op1_imm,
   input  logic [5:0]         d_fn,
   input  logic [p_naddr-1:0] d_waddr,
   input  logic               d_wen,
   input  logic               d_is_load,
   output logic               x_val,
   input  logic               x_rdy,
   output logic [p_nbits-1:0] x_in0,
   output logic [p_nbits-1:0] x_in1,
   output logic [5:0]         x_fn,
   output logic [p_naddr-1:0] x_waddr,
   output logic               x_wen,
   output logic               x_is_load,
   input  logic [p_nbits-1:0] x_result,
   input  logic               m_val,
   input  logic               m_wen,
   input  logic [p_naddr-1:0] m_waddr,
   input  logic [p_nbits-1:0] m_data,
   input  logic               w_val,
   input  logic               w_wen,
   input  logic [p_naddr-1:0] w_waddr,
   input  logic [p_nbits-1:0] w_data,
   input  logic               squash
);
   logic [1:0][p_naddr-1:0] src;
   logic [1:0][p_nbits-1:0] rf, opnd;
   logic [1:0]              used, busy;
   logic                    hazard, acc;
   assign src  = {d_rs2_addr, d_rs1_addr};
   assign rf   = {d_rs2_data, d_rs1_data};
   assign used = {~d_op1_imm, 1'b1};
`ifndef PROC_OPND_BYPASS_EN
   logic unused_fwd;
   assign unused_fwd = ^{x_result, m_data, w_data};
`endif
   always_comb begin
      opnd = rf;
      busy = '0;
      for (int i = 0; i < 2; i++) begin
`ifdef PROC_OPND_BYPASS_EN
         // newest producer wins; a load in X has no data yet and is handled as a hazard
         opnd[i] = src[i] == '0 ? '0 :
                   (x_val & x_wen & ~x_is_load & x_waddr == src[i]) ? x_result :
                   (m_val & m_wen & m_waddr == src[i]) ? m_data :
                   (w_val & w_wen & w_waddr == src[i]) ? w_data : rf[i];
         busy[i] = used[i] & x_val & x_is_load & x_wen & x_waddr != '0 & x_waddr == src[i];
`else
         busy[i] = used[i] & src[i] != '0 &
                   ((x_val & x_wen & x_waddr == src[i]) |
                    (m_val & m_wen & m_waddr == src[i]) |
                    (w_val & w_wen & w_waddr == src[i]));
`endif
      end
   end
   assign hazard = |busy;
   assign d_rdy  = (~x_val | x_rdy) & ~hazard & ~squash;
   assign acc    = d_val & d_rdy;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_val     <= 1'b0;
         x_in0     <= '0;
         x_in1     <= '0;
         x_fn      <= '0;
         x_waddr   <= '0;
         x_wen     <= 1'b0;
         x_is_load <= 1'b0;
      end else if (~x_val | x_rdy | squash) begin
         x_val <= acc;
         if (acc) begin
            x_in0     <= opnd[0];
            x_in1     <= d_op1_imm ? d_imm : opnd[1];
            x_fn      <= d_fn;
            x_waddr   <= d_waddr;
            x_wen     <= d_wen;
            x_is_load <= d_is_load;
         end
      end
   end
endmodule
